spi_load_sequencer: RTL and testbench



---
 rtl/spi_load_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_spi_load_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_load_sequencer.sv
// spi_load_sequencer: parses SPI frames (command, optional big-endian length,
// payload) and turns payload bytes into sequential memory writes.
// Ports:
//   SPI_Control_CLOCK_50     system clock
//   SPI_Control_RESET_InHigh async active-high reset
//   rx_byte / rx_valid       received byte and its one-cycle strobe
//   ss_active                synchronized frame-open level
//   mem_ready                memory accepts the pending write this cycle
//   wr_en/wr_addr/wr_data    write request (held until mem_ready)
//   wr_is_weight             1 = weight memory, 0 = image buffer
//   frame_done               one-cycle pulse on a successful frame
//   image_loaded             complete image present
//   weight_loaded            complete weight block present
//   err_code                 0 none, 1 bad command, 2 overrun, 3 abort
module spi_load_sequencer #(
  parameter int unsigned IMAGEWIDTH    = 784,
  parameter int unsigned DATAWIDTH_BUS = 8,
  parameter int unsigned ADDRESS_WIDTH = 16
) (
  input  logic                     SPI_Control_CLOCK_50,
  input  logic                     SPI_Control_RESET_InHigh,
  input  logic [DATAWIDTH_BUS-1:0] rx_byte,
  input  logic                     rx_valid,
  input  logic                     ss_active,
  input  logic                     mem_ready,
  output logic                     wr_en,
  output logic [ADDRESS_WIDTH-1:0] wr_addr,
  output logic [DATAWIDTH_BUS-1:0] wr_data,
  output logic                     wr_is_weight,
  output logic                     frame_done,
  output logic                     image_loaded,
  output logic                     weight_loaded,
  output logic [1:0]               err_code
);

  localparam logic [DATAWIDTH_BUS-1:0] CMD_IMAGE  = DATAWIDTH_BUS'(1);
  localparam logic [DATAWIDTH_BUS-1:0] CMD_WEIGHT = DATAWIDTH_BUS'(2);
  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_BAD_CMD = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_LEN_HI, S_LEN_LO, S_DATA, S_DONE, S_DRAIN
  } state_t;

  state_t                   state, state_n;
  logic                     ss_prev;
  logic [ADDRESS_WIDTH-1:0] count, count_n;
  logic [ADDRESS_WIDTH-1:0] len, len_n;
  logic                     wr_en_n, wr_is_weight_n, frame_done_n;
  logic [ADDRESS_WIDTH-1:0] wr_addr_n;
  logic [DATAWIDTH_BUS-1:0] wr_data_n;
  logic                     image_loaded_n, weight_loaded_n;
  logic [1:0]               err_code_n;
  logic                     handshake;
  logic [ADDRESS_WIDTH-1:0] count_inc;

  assign handshake = wr_en & mem_ready;
  assign count_inc = count + ADDRESS_WIDTH'(1);

  // State and output registers
  always_ff @(posedge SPI_Control_CLOCK_50 or posedge SPI_Control_RESET_InHigh) begin
    if (SPI_Control_RESET_InHigh) begin
      state         <= S_IDLE;
      ss_prev       <= 1'b0;
      count         <= '0;
      len           <= '0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      wr_is_weight  <= 1'b0;
      frame_done    <= 1'b0;
      image_loaded  <= 1'b0;
      weight_loaded <= 1'b0;
      err_code      <= ERR_NONE;
    end else begin
      state         <= state_n;
      ss_prev       <= ss_active;
      count         <= count_n;
      len           <= len_n;
      wr_en         <= wr_en_n;
      wr_addr       <= wr_addr_n;
      wr_data       <= wr_data_n;
      wr_is_weight  <= wr_is_weight_n;
      frame_done    <= frame_done_n;
      image_loaded  <= image_loaded_n;
      weight_loaded <= weight_loaded_n;
      err_code      <= err_code_n;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n         = state;
    count_n         = count;
    len_n           = len;
    wr_en_n         = wr_en;
    wr_addr_n       = wr_addr;
    wr_data_n       = wr_data;
    wr_is_weight_n  = wr_is_weight;
    frame_done_n    = 1'b0;
    image_loaded_n  = image_loaded;
    weight_loaded_n = weight_loaded;
    err_code_n      = err_code;

    case (state)
      S_IDLE: begin
        wr_en_n = 1'b0;
        if (ss_active && !ss_prev) begin
          state_n    = S_CMD;
          err_code_n = ERR_NONE;
          count_n    = '0;
        end
      end

      S_CMD: begin
        if (!ss_active) begin
          err_code_n = ERR_ABORT;
          state_n    = S_IDLE;
        end else if (rx_valid) begin
          if (rx_byte == CMD_IMAGE) begin
            wr_is_weight_n = 1'b0;
            len_n          = ADDRESS_WIDTH'(IMAGEWIDTH);
            image_loaded_n = 1'b0;
            count_n        = '0;
            state_n        = S_DATA;
          end else if (rx_byte == CMD_WEIGHT) begin
            wr_is_weight_n  = 1'b1;
            weight_loaded_n = 1'b0;
            state_n         = S_LEN_HI;
          end else begin
            err_code_n = ERR_BAD_CMD;
            state_n    = S_DRAIN;
          end
        end
      end

      S_LEN_HI: begin
        if (!ss_active) begin
          err_code_n = ERR_ABORT;
          state_n    = S_IDLE;
        end else if (rx_valid) begin
          len_n   = ADDRESS_WIDTH'({rx_byte, {DATAWIDTH_BUS{1'b0}}});
          state_n = S_LEN_LO;
        end
      end

      S_LEN_LO: begin
        if (!ss_active) begin
          err_code_n = ERR_ABORT;
          state_n    = S_IDLE;
        end else if (rx_valid) begin
          len_n   = len | ADDRESS_WIDTH'(rx_byte);
          count_n = '0;
          if ((len | ADDRESS_WIDTH'(rx_byte)) == '0) begin
            err_code_n = ERR_BAD_CMD;
            state_n    = S_DRAIN;
          end else begin
            state_n = S_DATA;
          end
        end
      end

      S_DATA: begin
        if (!ss_active) begin
          err_code_n = ERR_ABORT;
          wr_en_n    = 1'b0;
          state_n    = S_IDLE;
        end else begin
          if (handshake) begin
            count_n = count_inc;
            wr_en_n = 1'b0;
          end
          // Final handshake wins over a same-cycle byte, which is surplus
          if (handshake && (count == len - ADDRESS_WIDTH'(1))) begin
            state_n      = S_DONE;
            frame_done_n = 1'b1;
            if (wr_is_weight) weight_loaded_n = 1'b1;
            else              image_loaded_n  = 1'b1;
          end else if (rx_valid) begin
            if (wr_en && !mem_ready) begin
              err_code_n = ERR_OVERRUN;
              wr_en_n    = 1'b0;
              state_n    = S_DRAIN;
            end else begin
              wr_en_n   = 1'b1;
              wr_addr_n = handshake ? count_inc : count;
              wr_data_n = rx_byte;
            end
          end
        end
      end

      S_DONE: begin
        state_n = S_DRAIN;
      end

      S_DRAIN: begin
        wr_en_n = 1'b0;
        if (!ss_active) state_n = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
        wr_en_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_load_sequencer.sv
// tb_spi_load_sequencer: directed scenario tests for spi_load_sequencer.
module tb_spi_load_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        ss_active;
  logic        mem_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_is_weight;
  logic        frame_done;
  logic        image_loaded;
  logic        weight_loaded;
  logic [1:0]  err_code;

  int n_pass  = 0;
  int n_total = 0;
  int fd_cnt  = 0;
  logic [24:0] wq[$];

  spi_load_sequencer dut (
    .SPI_Control_CLOCK_50    (clk),
    .SPI_Control_RESET_InHigh(rst),
    .rx_byte                 (rx_byte),
    .rx_valid                (rx_valid),
    .ss_active               (ss_active),
    .mem_ready               (mem_ready),
    .wr_en                   (wr_en),
    .wr_addr                 (wr_addr),
    .wr_data                 (wr_data),
    .wr_is_weight            (wr_is_weight),
    .frame_done              (frame_done),
    .image_loaded            (image_loaded),
    .weight_loaded           (weight_loaded),
    .err_code                (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record completed writes and frame_done cycles mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en && mem_ready) wq.push_back({wr_is_weight, wr_addr, wr_data});
      if (frame_done) fd_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic open_frame();
    wq.delete();
    fd_cnt    = 0;
    ss_active = 1'b1;
    tick();
    tick();
  endtask

  task automatic close_frame();
    ss_active = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_byte = 8'h00; rx_valid = 1'b0; ss_active = 1'b0; mem_ready = 1'b1;
    tick();
    tick();
    n_total++;
    if ({wr_en, wr_addr, wr_data, wr_is_weight, frame_done, image_loaded,
         weight_loaded, err_code} !== 31'd0)
      $display("FAIL reset_outputs: got en=%0b addr=%0h data=%0h w=%0b fd=%0b il=%0b wl=%0b err=%0d want all 0",
               wr_en, wr_addr, wr_data, wr_is_weight, frame_done, image_loaded, weight_loaded, err_code);
    else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_image_frame(input string tag);
    int errs;
    open_frame();
    n_total++;
    if (err_code !== 2'd0) $display("FAIL %s_err_cleared_at_start: got %0d want 0", tag, err_code);
    else n_pass++;
    mem_ready = 1'b1;
    send_byte(8'h01);
    for (int i = 0; i < 784; i++) send_byte(8'(i % 16));
    for (int i = 0; i < 4; i++) tick();
    n_total++;
    if (wq.size() !== 784) $display("FAIL %s_write_count: got %0d want 784", tag, wq.size());
    else n_pass++;
    errs = 0;
    for (int i = 0; i < wq.size() && i < 784; i++)
      if (wq[i] !== {1'b0, 16'(i), 8'(i % 16)}) errs++;
    n_total++;
    if (errs !== 0) $display("FAIL %s_write_contents: got %0d bad entries want 0", tag, errs);
    else n_pass++;
    n_total++;
    if (fd_cnt !== 1) $display("FAIL %s_frame_done_cycles: got %0d want 1", tag, fd_cnt);
    else n_pass++;
    n_total++;
    if ({image_loaded, err_code} !== 3'b1_00)
      $display("FAIL %s_status: got il=%0b err=%0d want il=1 err=0", tag, image_loaded, err_code);
    else n_pass++;
    close_frame();
  endtask

  task automatic test_weight_frame();
    logic [7:0] vals [3];
    vals[0] = 8'hAA; vals[1] = 8'hBB; vals[2] = 8'hCC;
    open_frame();
    mem_ready = 1'b1;
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) begin
      mem_ready = 1'b0;
      send_byte(vals[i]);
      tick();
      n_total++;
      if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'(i), vals[i]})
        $display("FAIL weight_held_req%0d: got en=%0b addr=%0h data=%0h want en=1 addr=%0h data=%0h",
                 i, wr_en, wr_addr, wr_data, i, vals[i]);
      else n_pass++;
      mem_ready = 1'b1;
      tick();
    end
    tick();
    tick();
    n_total++;
    if (wq.size() !== 3 || wq[0] !== {1'b1, 16'd0, 8'hAA} || wq[1] !== {1'b1, 16'd1, 8'hBB} ||
        wq[2] !== {1'b1, 16'd2, 8'hCC})
      $display("FAIL weight_writes: got %0d writes want 3 at addr 0..2 data AA,BB,CC", wq.size());
    else n_pass++;
    n_total++;
    if ({fd_cnt == 1, weight_loaded, image_loaded, err_code} !== 5'b111_00)
      $display("FAIL weight_status: got fd=%0d wl=%0b il=%0b err=%0d want fd=1 wl=1 il=1 err=0",
               fd_cnt, weight_loaded, image_loaded, err_code);
    else n_pass++;
    close_frame();
  endtask

  task automatic test_bad_command();
    open_frame();
    mem_ready = 1'b1;
    send_byte(8'h7E);
    for (int i = 0; i < 5; i++) send_byte(8'(8'h01 + i));
    tick();
    n_total++;
    if ({wq.size() == 0, fd_cnt == 0, err_code} !== 4'b11_01)
      $display("FAIL badcmd_effects: got writes=%0d fd=%0d err=%0d want 0 0 1", wq.size(), fd_cnt, err_code);
    else n_pass++;
    close_frame();
    tick();
    n_total++;
    if ({err_code, image_loaded, weight_loaded} !== 4'b01_11)
      $display("FAIL badcmd_sticky: got err=%0d il=%0b wl=%0b want err=1 il=1 wl=1",
               err_code, image_loaded, weight_loaded);
    else n_pass++;
  endtask

  task automatic test_overrun();
    open_frame();
    mem_ready = 1'b1;
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h04);
    mem_ready = 1'b0;
    send_byte(8'h11);
    n_total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 16'd0, 8'h11})
      $display("FAIL overrun_first_req: got en=%0b addr=%0h data=%0h want 1 0 11", wr_en, wr_addr, wr_data);
    else n_pass++;
    send_byte(8'h22);
    n_total++;
    if ({wr_en, err_code} !== 3'b0_10)
      $display("FAIL overrun_detect: got en=%0b err=%0d want en=0 err=2", wr_en, err_code);
    else n_pass++;
    mem_ready = 1'b1;
    tick();
    tick();
    n_total++;
    if ({wq.size() == 0, weight_loaded, fd_cnt == 0} !== 3'b101)
      $display("FAIL overrun_status: got writes=%0d wl=%0b fd=%0d want 0 0 0", wq.size(), weight_loaded, fd_cnt);
    else n_pass++;
    close_frame();
  endtask

  task automatic test_abort();
    open_frame();
    mem_ready = 1'b1;
    send_byte(8'h01);
    for (int i = 0; i < 100; i++) send_byte(8'(i % 16));
    tick();
    ss_active = 1'b0;
    tick();
    tick();
    n_total++;
    if ({err_code, image_loaded, wr_en} !== 4'b11_0_0)
      $display("FAIL abort_status: got err=%0d il=%0b en=%0b want 3 0 0", err_code, image_loaded, wr_en);
    else n_pass++;
    n_total++;
    if (wq.size() !== 100 || fd_cnt !== 0)
      $display("FAIL abort_writes: got writes=%0d fd=%0d want 100 0", wq.size(), fd_cnt);
    else n_pass++;
    tick();
  endtask

  task automatic test_extra_bytes();
    open_frame();
    mem_ready = 1'b1;
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h10);
    send_byte(8'h20);
    send_byte(8'h30);
    send_byte(8'h40);
    tick();
    tick();
    n_total++;
    if (wq.size() !== 2 || wq[0] !== {1'b1, 16'd0, 8'h10} || wq[1] !== {1'b1, 16'd1, 8'h20})
      $display("FAIL extra_writes: got %0d writes want 2 (0:10, 1:20)", wq.size());
    else n_pass++;
    n_total++;
    if ({fd_cnt == 1, weight_loaded, err_code, wr_en} !== 5'b11_00_0)
      $display("FAIL extra_status: got fd=%0d wl=%0b err=%0d en=%0b want 1 1 0 0",
               fd_cnt, weight_loaded, err_code, wr_en);
    else n_pass++;
    close_frame();
  endtask

  task automatic test_reset_midframe();
    open_frame();
    mem_ready = 1'b0;
    send_byte(8'h01);
    send_byte(8'h5A);
    n_total++;
    if (wr_en !== 1'b1) $display("FAIL midreset_pending: got en=%0b want 1", wr_en);
    else n_pass++;
    #1;
    rst = 1'b1;
    #1;
    n_total++;
    if ({wr_en, wr_addr, wr_data, wr_is_weight, frame_done, image_loaded,
         weight_loaded, err_code} !== 31'd0)
      $display("FAIL midreset_outputs: got en=%0b addr=%0h data=%0h il=%0b wl=%0b err=%0d want all 0",
               wr_en, wr_addr, wr_data, image_loaded, weight_loaded, err_code);
    else n_pass++;
    ss_active = 1'b0;
    mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    n_total++;
    if (wq.size() !== 0) $display("FAIL midreset_no_write: got %0d writes want 0", wq.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_image_frame("image");
    test_weight_frame();
    test_bad_command();
    test_overrun();
    test_abort();
    test_image_frame("image_after_abort");
    test_extra_bytes();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
